// File: rtl/row_vnu_ctrl_pkg.sv
// Shared state encoding, IB-ROM segment codes and latency helpers for the
// row VNU iteration controller.
package row_vnu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REFRESH = 3'd1,
      ST_LOAD    = 3'd2,
      ST_DECODE  = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_NEXT    = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   localparam logic [1:0] SEL_VN_F0 = 2'd0;
   localparam logic [1:0] SEL_VN_F1 = 2'd1;
   localparam logic [1:0] SEL_DN    = 2'd2;

   localparam int PHASE_BW = 8;

   // Cycles needed for the last latched c2v to leave the F0/F1/DNU pipes.
   function automatic int drain_len(input int vn_depth, input int dn_depth);
      return 32'sd1 + 32'sd2 * vn_depth + dn_depth;
   endfunction

   function automatic int valid_dly(input int vn_depth);
      return 32'sd1 + 32'sd2 * vn_depth;
   endfunction

endpackage

// File: rtl/ib_ram_refresh_seq.sv
// IB-ROM page walker for one REFRESH pass; write strobes and addresses are
// delayed by ROM_RD_LAT so they line up with the ROM read data.
module ib_ram_refresh_seq
   import row_vnu_ctrl_pkg::*;
#(
   parameter int VN_PAGE_ADDR_BW = 6,
   parameter int DN_PAGE_ADDR_BW = 6,
   parameter int VN_PAGE_WORDS   = 64,
   parameter int DN_PAGE_WORDS   = 64,
   parameter int ROM_RD_LAT      = 1
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     go_i,
   output logic [1:0]               rom_sel_o,
   output logic [VN_PAGE_ADDR_BW:0] rom_word_o,
   output logic [2:0]               we_o,
   output logic [VN_PAGE_ADDR_BW:0] addr0_o,
   output logic [VN_PAGE_ADDR_BW:0] addr1_o,
   output logic [DN_PAGE_ADDR_BW:0] addr2_o,
   output logic                     finished_o
);
   localparam int VW = VN_PAGE_ADDR_BW + 1;
   localparam int DW = DN_PAGE_ADDR_BW + 1;

   logic          active_q, active_d;
   logic [1:0]    sel_q, sel_d;
   logic [VW-1:0] word_q, word_d;
   logic          seg_end_s, last_s;
   logic [2:0]    we_s;
   logic [VW-1:0] a0_s, a1_s;
   logic [DW-1:0] a2_s;

   logic [2:0]    we_p   [ROM_RD_LAT];
   logic [VW-1:0] a0_p   [ROM_RD_LAT];
   logic [VW-1:0] a1_p   [ROM_RD_LAT];
   logic [DW-1:0] a2_p   [ROM_RD_LAT];
   logic          last_p [ROM_RD_LAT];

   // Segment/word walker: VN F0 page, VN F1 page, then DN page.
   always_comb begin
      active_d  = active_q;
      sel_d     = sel_q;
      word_d    = word_q;
      seg_end_s = (sel_q == SEL_DN) ? (word_q == VW'(DN_PAGE_WORDS - 1))
                                    : (word_q == VW'(VN_PAGE_WORDS - 1));
      if (go_i) begin
         active_d = 1'b1;
         sel_d    = SEL_VN_F0;
         word_d   = '0;
      end else if (active_q && seg_end_s) begin
         word_d = '0;
         if (sel_q == SEL_DN) begin
            active_d = 1'b0;
            sel_d    = SEL_VN_F0;
         end else begin
            sel_d = sel_q + 2'd1;
         end
      end else if (active_q) begin
         word_d = word_q + VW'(1);
      end else begin
         word_d = word_q;
      end
   end

   // Decode the presented ROM word into the strobe/address it will produce.
   always_comb begin
      we_s   = 3'b000;
      a0_s   = '0;
      a1_s   = '0;
      a2_s   = '0;
      last_s = active_q && (sel_q == SEL_DN) && seg_end_s;
      if (active_q) begin
         case (sel_q)
            SEL_VN_F0: begin we_s = 3'b001; a0_s = word_q;     end
            SEL_VN_F1: begin we_s = 3'b010; a1_s = word_q;     end
            SEL_DN:    begin we_s = 3'b100; a2_s = DW'(word_q); end
            default:   begin we_s = 3'b000; end
         endcase
      end else begin
         we_s = 3'b000;
      end
   end

   // Walker registers and the ROM-latency alignment pipeline.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         active_q <= 1'b0;
         sel_q    <= SEL_VN_F0;
         word_q   <= '0;
         for (int i = 0; i < ROM_RD_LAT; i++) begin
            we_p[i]   <= 3'b000;
            a0_p[i]   <= '0;
            a1_p[i]   <= '0;
            a2_p[i]   <= '0;
            last_p[i] <= 1'b0;
         end
      end else begin
         active_q  <= active_d;
         sel_q     <= sel_d;
         word_q    <= word_d;
         we_p[0]   <= we_s;
         a0_p[0]   <= a0_s;
         a1_p[0]   <= a1_s;
         a2_p[0]   <= a2_s;
         last_p[0] <= last_s;
         for (int i = 1; i < ROM_RD_LAT; i++) begin
            we_p[i]   <= we_p[i-1];
            a0_p[i]   <= a0_p[i-1];
            a1_p[i]   <= a1_p[i-1];
            a2_p[i]   <= a2_p[i-1];
            last_p[i] <= last_p[i-1];
         end
      end
   end

   assign rom_sel_o  = sel_q;
   assign rom_word_o = word_q;
   assign we_o       = we_p[ROM_RD_LAT-1];
   assign addr0_o    = a0_p[ROM_RD_LAT-1];
   assign addr1_o    = a1_p[ROM_RD_LAT-1];
   assign addr2_o    = a2_p[ROM_RD_LAT-1];
   assign finished_o = last_p[ROM_RD_LAT-1];

endmodule

// File: rtl/row_vnu_iter_ctrl.sv
// Per-iteration controller for a row of partial-VNU datapaths.
// Define ROW_VNU_EARLY_TERM_EN to stop on syndrome_zero at the end of DRAIN.
module row_vnu_iter_ctrl
   import row_vnu_ctrl_pkg::*;
#(
   parameter int VN_PAGE_ADDR_BW   = 6,
   parameter int DN_PAGE_ADDR_BW   = 6,
   parameter int VN_PAGE_WORDS     = 64,
   parameter int DN_PAGE_WORDS     = 64,
   parameter int ROM_RD_LAT        = 1,
   parameter int VN_PIPELINE_DEPTH = 3,
   parameter int DN_PIPELINE_DEPTH = 3,
   parameter int MULTI_FRAME_NUM   = 2,
   parameter int LAYER_NUM         = 4,
   parameter int ITER_BW           = 4
) (
   input  logic                     read_clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [ITER_BW-1:0]       max_iter,
   input  logic                     syndrome_zero,
   output logic                     busy,
   output logic                     done,
   output logic [ITER_BW-1:0]       iter_cnt,
   output logic [1:0]               rom_sel,
   output logic [VN_PAGE_ADDR_BW:0] rom_word,
   output logic [2:0]               ib_ram_we,
   output logic [VN_PAGE_ADDR_BW:0] page_addr_ram_0,
   output logic [VN_PAGE_ADDR_BW:0] page_addr_ram_1,
   output logic [DN_PAGE_ADDR_BW:0] page_addr_ram_2,
   output logic                     c2v_parallel_load,
   output logic                     c2v_latch_en,
   output logic                     read_addr_offset,
   output logic                     v2c_src,
   output logic                     v2c_valid,
   output logic                     hd_valid
);
   localparam int DEC_LEN = LAYER_NUM * MULTI_FRAME_NUM;
   localparam int DRN_LEN = drain_len(VN_PIPELINE_DEPTH, DN_PIPELINE_DEPTH);
   localparam int V_DLY   = valid_dly(VN_PIPELINE_DEPTH);

   state_e                 state_q, state_d;
   logic [PHASE_BW-1:0]    phase_q, phase_d;
   logic [ITER_BW-1:0]     iter_q, iter_d, max_q, max_d;
   logic                   last_iter_s, stop_s, go_s, fin_s;
   logic                   busy_q, busy_d, done_q, done_d, load_q, load_d;
   logic                   en_q, en_d, off_q, off_d, src_q, src_d;
   logic [V_DLY-1:0]       v2c_sr_q;
   logic [DN_PIPELINE_DEPTH-1:0] hd_sr_q;

   // Compared one bit wider so max_iter = 2^ITER_BW-1 never wraps.
   assign last_iter_s = ({1'b0, iter_q} + {{ITER_BW{1'b0}}, 1'b1}) == {1'b0, max_q};
`ifdef ROW_VNU_EARLY_TERM_EN
   assign stop_s = last_iter_s | syndrome_zero;
`else
   logic unused_syndrome_s;
   assign unused_syndrome_s = syndrome_zero;
   assign stop_s = last_iter_s;
`endif

   ib_ram_refresh_seq #(
      .VN_PAGE_ADDR_BW (VN_PAGE_ADDR_BW),
      .DN_PAGE_ADDR_BW (DN_PAGE_ADDR_BW),
      .VN_PAGE_WORDS   (VN_PAGE_WORDS),
      .DN_PAGE_WORDS   (DN_PAGE_WORDS),
      .ROM_RD_LAT      (ROM_RD_LAT)
   ) u_refresh (
      .clk_i      (read_clk),
      .rstn_i     (rstn),
      .go_i       (go_s),
      .rom_sel_o  (rom_sel),
      .rom_word_o (rom_word),
      .we_o       (ib_ram_we),
      .addr0_o    (page_addr_ram_0),
      .addr1_o    (page_addr_ram_1),
      .addr2_o    (page_addr_ram_2),
      .finished_o (fin_s)
   );

   // State register plus iteration bookkeeping.
   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         iter_q  <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         iter_q  <= iter_d;
         max_q   <= max_d;
      end
   end

   // Next-state logic; the NEXT decision is folded into the last DRAIN cycle.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      max_d   = max_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_REFRESH;
               iter_d  = '0;
               max_d   = (max_iter == '0) ? ITER_BW'(1) : max_iter;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REFRESH: begin
            if (fin_s) begin
               state_d = (iter_q == '0) ? ST_LOAD : ST_DECODE;
            end else begin
               state_d = ST_REFRESH;
            end
         end
         ST_LOAD: state_d = ST_DECODE;
         ST_DECODE: begin
            if (phase_q == PHASE_BW'(DEC_LEN - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_DECODE;
            end
         end
         ST_DRAIN: begin
            if (phase_q != PHASE_BW'(DRN_LEN - 1)) begin
               state_d = ST_DRAIN;
            end else if (stop_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_REFRESH;
               iter_d  = iter_q + ITER_BW'(1);
            end
         end
         ST_NEXT: state_d = ST_IDLE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      phase_d = (state_d != state_q) ? '0 : phase_q + PHASE_BW'(1);
   end

   // Output decode from the upcoming state so every pin leaves a flop.
   always_comb begin
      go_s   = (state_d == ST_REFRESH) && (state_q != ST_REFRESH);
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
      load_d = (state_d == ST_LOAD);
      en_d   = (state_d == ST_DECODE);
      src_d  = (state_d != ST_IDLE) && (iter_d != '0);
      if ((state_d == ST_DECODE) && (state_q != ST_DECODE)) begin
         off_d = 1'b0;
      end else if ((state_d == ST_DECODE) || (state_d == ST_DRAIN)) begin
         off_d = ~off_q;
      end else begin
         off_d = 1'b0;
      end
   end

   // Registered control outputs and the datapath-latency valid delay lines.
   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         load_q   <= 1'b0;
         en_q     <= 1'b0;
         off_q    <= 1'b0;
         src_q    <= 1'b0;
         v2c_sr_q <= '0;
         hd_sr_q  <= '0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         load_q   <= load_d;
         en_q     <= en_d;
         off_q    <= off_d;
         src_q    <= src_d;
         v2c_sr_q <= {v2c_sr_q[V_DLY-2:0], en_q};
         hd_sr_q  <= {hd_sr_q[DN_PIPELINE_DEPTH-2:0], v2c_sr_q[V_DLY-1]};
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign iter_cnt          = iter_q;
   assign c2v_parallel_load = load_q;
   assign c2v_latch_en      = en_q;
   assign read_addr_offset  = off_q;
   assign v2c_src           = src_q;
   assign v2c_valid         = v2c_sr_q[V_DLY-1];
   assign hd_valid          = hd_sr_q[DN_PIPELINE_DEPTH-1];

endmodule

// File: tb/tb_row_vnu_iter_ctrl.sv
// Scoreboard bench for row_vnu_iter_ctrl: each start pushes the expected
// transaction profile, a monitor tallies the DUT's behaviour and checks on done.
module tb_row_vnu_iter_ctrl;
   localparam int ITER_BW  = 4;
   localparam int VW       = 7;
   localparam int DW       = 7;
   localparam int WORDS    = 64;
   localparam int DEC      = 8;
   localparam int DRN      = 10;
   localparam int REF      = 3 * WORDS + 1;
   localparam int PER_ITER = REF + DEC + DRN;

   logic               read_clk = 1'b0;
   logic               rstn, start, syndrome_zero;
   logic [ITER_BW-1:0] max_iter;
   logic               busy, done, c2v_parallel_load, c2v_latch_en;
   logic               read_addr_offset, v2c_src, v2c_valid, hd_valid;
   logic [ITER_BW-1:0] iter_cnt;
   logic [1:0]         rom_sel;
   logic [VW-1:0]      rom_word, page_addr_ram_0, page_addr_ram_1;
   logic [DW-1:0]      page_addr_ram_2;
   logic [2:0]         ib_ram_we;
   logic [44:0]        all_outs;

   row_vnu_iter_ctrl dut (
      .read_clk(read_clk), .rstn(rstn), .start(start), .max_iter(max_iter),
      .syndrome_zero(syndrome_zero), .busy(busy), .done(done), .iter_cnt(iter_cnt),
      .rom_sel(rom_sel), .rom_word(rom_word), .ib_ram_we(ib_ram_we),
      .page_addr_ram_0(page_addr_ram_0), .page_addr_ram_1(page_addr_ram_1),
      .page_addr_ram_2(page_addr_ram_2), .c2v_parallel_load(c2v_parallel_load),
      .c2v_latch_en(c2v_latch_en), .read_addr_offset(read_addr_offset),
      .v2c_src(v2c_src), .v2c_valid(v2c_valid), .hd_valid(hd_valid)
   );

   always #5 read_clk = ~read_clk;

   typedef struct { int t_start; int n; } exp_t;
   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   e_target = -1;
   bit   mon_clear = 1'b0;

   int we_cnt [3];
   int load_cnt, busy_cnt, src_cnt, en_cnt, v2c_cnt, hd_cnt;
   int align_err, off_err, rise_err, dec_idx, drain_left, en_rise, v2c_rise;
   logic [1:0]    p_sel;
   logic [VW-1:0] p_word;
   logic          p_en, p_v2c, p_hd, p_off;

   always @(posedge read_clk) cyc <= cyc + 1;

   // Syndrome passes throughout the targeted iteration only.
   assign syndrome_zero = busy && (e_target >= 0) && (int'(iter_cnt) == e_target);
   assign all_outs = {busy, done, iter_cnt, rom_sel, rom_word, ib_ram_we,
                      page_addr_ram_0, page_addr_ram_1, page_addr_ram_2,
                      c2v_parallel_load, c2v_latch_en, read_addr_offset,
                      v2c_src, v2c_valid, hd_valid};

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Number of iterations a run must perform.
   function automatic int iters_run(input int mx, input int e);
      int eff;
      eff = (mx == 0) ? 1 : mx;
`ifdef ROW_VNU_EARLY_TERM_EN
      if (e >= 0 && e < eff) return e + 1;
`endif
      return (e < -1) ? 1 : eff;
   endfunction

   task automatic clear_acc();
      for (int b = 0; b < 3; b++) we_cnt[b] = 0;
      load_cnt = 0; busy_cnt = 0; src_cnt = 0; en_cnt = 0; v2c_cnt = 0; hd_cnt = 0;
      align_err = 0; off_err = 0; rise_err = 0;
   endtask

   initial begin : monitor
      exp_t x;
      int   sel, addr;
      clear_acc();
      dec_idx = 0; drain_left = 0; en_rise = 0; v2c_rise = 0;
      p_sel = '0; p_word = '0; p_en = 1'b0; p_v2c = 1'b0; p_hd = 1'b0; p_off = 1'b0;
      forever begin
         @(negedge read_clk);
         if (!rstn || mon_clear) begin
            clear_acc();
            mon_clear = 1'b0;
            dec_idx = 0; drain_left = 0;
            p_sel = '0; p_word = '0; p_en = 1'b0; p_v2c = 1'b0; p_hd = 1'b0; p_off = 1'b0;
         end else begin
            for (int b = 0; b < 3; b++) if (ib_ram_we[b]) we_cnt[b]++;
            if (ib_ram_we != 3'b000) begin
               if (!$onehot(ib_ram_we)) align_err++;
               else begin
                  sel  = ib_ram_we[0] ? 0 : (ib_ram_we[1] ? 1 : 2);
                  addr = (sel == 0) ? int'(page_addr_ram_0) :
                         (sel == 1) ? int'(page_addr_ram_1) : int'(page_addr_ram_2);
                  if (sel != int'(p_sel) || addr != int'(p_word)) align_err++;
               end
            end
            if (c2v_parallel_load) load_cnt++;
            if (busy) busy_cnt++;
            if (busy && v2c_src) src_cnt++;
            if (c2v_latch_en) en_cnt++;
            if (v2c_valid) v2c_cnt++;
            if (hd_valid) hd_cnt++;
            if (c2v_latch_en && !p_en) en_rise = cyc;
            if (v2c_valid && !p_v2c) begin
               if (cyc - en_rise != 7) rise_err++;
               v2c_rise = cyc;
            end
            if (hd_valid && !p_hd && (cyc - v2c_rise != 3)) rise_err++;
            if (c2v_latch_en) begin
               if (int'(read_addr_offset) != dec_idx % 2) off_err++;
               dec_idx++;
               drain_left = DRN;
            end else begin
               dec_idx = 0;
               if (drain_left > 0) begin
                  if (read_addr_offset == p_off) off_err++;
                  drain_left--;
               end
            end
            if (done) begin
               if (sb_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_done: done pulse with no pending start, iter_cnt=%0d", iter_cnt);
               end else begin
                  x = sb_q.pop_front();
                  chk("latency", cyc - x.t_start, 2 + PER_ITER * x.n);
                  chk("final_iter_cnt", iter_cnt, x.n - 1);
                  chk("busy_at_done", busy, 0);
                  chk("we0_count", we_cnt[0], WORDS * x.n);
                  chk("we1_count", we_cnt[1], WORDS * x.n);
                  chk("we2_count", we_cnt[2], WORDS * x.n);
                  chk("load_count", load_cnt, 1);
                  chk("busy_cycles", busy_cnt, 1 + PER_ITER * x.n);
                  chk("v2c_src_cycles", src_cnt, PER_ITER * (x.n - 1));
                  chk("latch_en_cycles", en_cnt, DEC * x.n);
                  chk("v2c_valid_cycles", v2c_cnt, DEC * x.n);
                  chk("hd_valid_cycles", hd_cnt, DEC * x.n);
                  chk("we_alignment_errs", align_err, 0);
                  chk("offset_errs", off_err, 0);
                  chk("valid_delay_errs", rise_err, 0);
               end
               clear_acc();
            end
            p_sel = rom_sel; p_word = rom_word; p_en = c2v_latch_en;
            p_v2c = v2c_valid; p_hd = hd_valid; p_off = read_addr_offset;
         end
      end
   end

   task automatic run_txn(input int mx, input int e, input bit poke_busy);
      exp_t x;
      int   budget;
      bit   got;
      @(negedge read_clk);
      e_target  = e;
      max_iter  = mx[ITER_BW-1:0];
      start     = 1'b1;
      x.t_start = cyc;
      x.n       = iters_run(mx, e);
      sb_q.push_back(x);
      @(negedge read_clk);
      start    = 1'b0;
      max_iter = ITER_BW'($urandom);
      if (poke_busy) begin
         repeat (40) @(negedge read_clk);
         start = 1'b1;
         @(negedge read_clk);
         start = 1'b0;
      end
      budget = 2 + PER_ITER * x.n + 50;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge read_clk);
         if (sb_q.size() == 0) got = 1'b1;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL done_timeout: no done within %0d cycles, want one", budget);
         sb_q.delete();
      end
      e_target = -1;
      repeat (3) @(negedge read_clk);
   endtask

   initial begin : driver
      bit got;
      rstn = 1'b0; start = 1'b0; max_iter = '0;
      repeat (3) @(negedge read_clk);
      chk("reset_outputs", all_outs, 0);
      rstn = 1'b1;
      run_txn(1, -1, 1'b1);
      run_txn(2, -1, 1'b0);
      run_txn(0, -1, 1'b0);
      run_txn(8, 2, 1'b0);
      // Reset in the middle of the VN F0 page refresh.
      @(negedge read_clk);
      max_iter = 4'd3; start = 1'b1;
      @(negedge read_clk);
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         if (busy && rom_word == 7'd30) got = 1'b1;
         else @(negedge read_clk);
      end
      chk("reached_word30", got, 1);
      rstn = 1'b0;
      @(posedge read_clk);
      #1;
      chk("reset_mid_outputs", all_outs, 0);
      rstn = 1'b1;
      mon_clear = 1'b1;
      repeat (5) @(negedge read_clk);
      chk("idle_after_reset", busy, 0);
      run_txn(1, -1, 1'b0);
      for (int k = 0; k < 4; k++)
         run_txn($urandom_range(0, 4), int'($urandom_range(0, 5)) - 1, 1'($urandom_range(0, 1)));
      run_txn(15, -1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/row_vnu_iter_ctrl.md
# row_vnu_iter_ctrl

Iteration controller for one row of partial-VNU datapaths: the VNU F0/F1 stages, the DNU stage, and their c2v input latches. Per decoding iteration it:
- refreshes the three IB-RAMs (VN F0, VN F1, DN) with that iteration's page from the IB-ROM;
- clears or enables the c2v latches;
- interleaves the multi-frame read offset across layers;
- tracks pipeline drain so downstream logic knows when v2c messages and hard decisions are valid.

It sits between the decoder top-level start/done handshake and the row VNU wrapper's control pins.

## Interface
Parameters:
- VN_PAGE_ADDR_BW, 6, VN IB-RAM page address width (port width is +1)
- DN_PAGE_ADDR_BW, 6, DN IB-RAM page address width (port width is +1)
- VN_PAGE_WORDS, 64, words written per VN IB-RAM refresh
- DN_PAGE_WORDS, 64, words written per DN IB-RAM refresh
- ROM_RD_LAT, 1, IB-ROM read latency in cycles
- VN_PIPELINE_DEPTH, 3, stages per VNU sub-datapath (F0, F1)
- DN_PIPELINE_DEPTH, 3, stages of DNU
- MULTI_FRAME_NUM, 2, interleaved frames (read_addr_offset is 1 bit, so only 2 is supported)
- LAYER_NUM, 4, layers per iteration
- ITER_BW, 4, iteration counter width

Ports:
- read_clk  in  1  sole clock
- rstn  in  1  synchronous active-low reset
- start  in  1  begin decoding; sampled only in IDLE
- max_iter  in  ITER_BW  iteration limit, latched at start; 0 is treated as 1
- syndrome_zero  in  1  parity-check pass flag, sampled at end of DRAIN
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle pulse
- iter_cnt  out  ITER_BW  current iteration index
- rom_sel  out  2  IB-ROM segment being read (0 = VN F0, 1 = VN F1, 2 = DN)
- rom_word  out  VN_PAGE_ADDR_BW+1  IB-ROM word index within the segment
- ib_ram_we  out  3  one-hot IB-RAM write enable
- page_addr_ram_0  out  VN_PAGE_ADDR_BW+1  VN F0 write address
- page_addr_ram_1  out  VN_PAGE_ADDR_BW+1  VN F1 write address
- page_addr_ram_2  out  DN_PAGE_ADDR_BW+1  DN write address
- c2v_parallel_load  out  1  clears the c2v latches
- c2v_latch_en  out  1  captures c2v into the latches
- read_addr_offset  out  1  multi-frame select
- v2c_src  out  1  0 in iteration 0, 1 afterwards
- v2c_valid  out  1  v2c outputs valid
- hd_valid  out  1  hard decisions valid

## Operation
The state machine has seven states: IDLE, REFRESH, LOAD, DECODE, DRAIN, NEXT, DONE.

- **IDLE**
  - All outputs are 0; this is also the reset value of every output.
  - On start=1: latch max_iter, set iter_cnt=0, go to REFRESH.
- **REFRESH**
  - rom_sel walks 0, 1, 2; rom_word counts 0..VN_PAGE_WORDS-1 (segments 0 and 1) and 0..DN_PAGE_WORDS-1 (segment 2).
  - rom_iter is implied by iter_cnt.
  - ib_ram_we[rom_sel] and the matching page_addr are rom_sel/rom_word delayed by ROM_RD_LAT registers, so ram_write_data aligns with them.
  - Exit after the final word plus ROM_RD_LAT flush cycles: to LOAD if iter_cnt==0, else to DECODE.
- **LOAD**
  - One cycle with c2v_parallel_load=1.
- **DECODE**
  - Lasts LAYER_NUM*MULTI_FRAME_NUM cycles.
  - c2v_latch_en=1 throughout.
  - read_addr_offset starts at 0 and toggles every cycle.
- **DRAIN**
  - Lasts 1 + 2*VN_PIPELINE_DEPTH + DN_PIPELINE_DEPTH cycles.
  - c2v_latch_en=0; read_addr_offset keeps toggling so in-flight data keeps its frame alignment.
- **NEXT** (zero-time decision at the end of DRAIN)
  - If iter_cnt+1 == max_iter (or early-terminated): go to DONE.
  - Else: iter_cnt++, v2c_src=1, go to REFRESH.
- **DONE**
  - done=1 and busy=0 for one cycle, then IDLE.
  - iter_cnt holds its final value until the next start.

Valid flags:
- v2c_valid = c2v_latch_en delayed by 1 + 2*VN_PIPELINE_DEPTH cycles.
- hd_valid = v2c_valid delayed by DN_PIPELINE_DEPTH cycles.

Boundary conditions:
- start while busy is ignored.
- rstn=0 in any state gives IDLE and reset values on the next edge. The valid-delay lines are cleared too, so no stale valids appear.
- The iteration counter never wraps: max_iter=2^ITER_BW-1 stops at that count.

## Timing
- Every output is registered.
- First REFRESH cycle is the cycle after start is sampled.
- REFRESH length = 2*VN_PAGE_WORDS + DN_PAGE_WORDS + ROM_RD_LAT cycles. With defaults: 193.
- The first ib_ram_we[0] is high ROM_RD_LAT cycles after rom_word=0 is presented.
- Consecutive segments are back-to-back: no idle cycle between the last write of RAM k and the first write of RAM k+1.
- With defaults, one iteration is 193 + 8 + 10 cycles, plus 1 LOAD cycle in iteration 0.

## Configuration
ROW_VNU_EARLY_TERM_EN:
- **Defined:** syndrome_zero=1 sampled in the last DRAIN cycle forces DONE regardless of iter_cnt.
- **Undefined:** syndrome_zero is ignored; decoding always runs max_iter iterations.

## Structure
- **Package row_vnu_ctrl_pkg:**
  - state enum;
  - rom_sel encodings (SEL_VN_F0=0, SEL_VN_F1=1, SEL_DN=2);
  - DRAIN_LEN and VALID_DLY localparam functions.
- **Sub-module ib_ram_refresh_seq:**
  - REFRESH walker and ROM-latency alignment pipeline;
  - start/finished handshake with the main state machine.

## Test plan
- **Single iteration:** max_iter=1, start pulse → done pulse 1+193+1+8+10 cycles later; exactly 192 ib_ram_we pulses (64 per bit); v2c_src stays 0.
- **Two iterations:** max_iter=2 → second REFRESH has no LOAD; v2c_src=1 in iteration 1; done 424 cycles after start; iter_cnt=1 at done.
- **Alignment:** in every cycle where ib_ram_we is high, page_addr equals rom_word from ROM_RD_LAT cycles earlier. DECODE shows read_addr_offset 0,1,0,1,…, and v2c_valid rises exactly 7 cycles after c2v_latch_en.
- **Early termination** (macro defined): max_iter=8 with syndrome_zero=1 during iteration 2's DRAIN → done with iter_cnt=2. With the macro undefined → done with iter_cnt=7.
- **Reset mid-REFRESH:** rstn=0 for 1 cycle at word 30 → next cycle all outputs 0, state IDLE; a new start then restarts at iter_cnt=0.
- **Corner cases:** start asserted while busy is ignored; max_iter=0 behaves as 1.
